// File: rtl/adc1_axil_pkg.sv
// Shared definitions for the ADC1 AXI4-Lite slave: register map, field positions,
// response codes, FSM state types and register word helpers.
package adc1_axil_pkg;

   localparam int unsigned ADC_W            = 12;
   localparam int unsigned CLKDIV_W         = 16;

   localparam logic [1:0]  REG_CTRL         = 2'd0;
   localparam logic [1:0]  REG_CLKDIV       = 2'd1;
   localparam logic [1:0]  REG_SAMPLE       = 2'd2;
   localparam logic [1:0]  REG_SCRATCH      = 2'd3;

   localparam int unsigned CTRL_EN_BIT      = 0;
   localparam int unsigned CTRL_IRQEN_BIT   = 1;
   localparam int unsigned SAMPLE_VALID_BIT = 31;
   localparam int unsigned SAMPLE_OVR_BIT   = 30;

   localparam logic [1:0]  RESP_OKAY        = 2'b00;

   typedef enum logic { W_IDLE, W_RESP } wstate_e;
   typedef enum logic { R_IDLE, R_DATA } rstate_e;

   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) begin
            res[i*8 +: 8] = new_v[i*8 +: 8];
         end else begin
            res[i*8 +: 8] = old_v[i*8 +: 8];
         end
      end
      return res;
   endfunction

   // Unimplemented bits of each register read back as zero.
   function automatic logic [31:0] reg_word(input logic [1:0]          sel,
                                             input logic [1:0]          ctrl,
                                             input logic [CLKDIV_W-1:0] clkdiv,
                                             input logic [31:0]         sample_word,
                                             input logic [31:0]         scratch);
      logic [31:0] res;
      case (sel)
         REG_CTRL:    res = {30'd0, ctrl};
         REG_CLKDIV:  res = {{(32-CLKDIV_W){1'b0}}, clkdiv};
         REG_SAMPLE:  res = sample_word;
         REG_SCRATCH: res = scratch;
         default:     res = 32'd0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/adc1_sample_capture.sv
// Holds the last ADC sample with its valid flag and sticky overrun flag;
// a read of SAMPLE clears the flags unless a new sample arrives in the same cycle.
module adc1_sample_capture
   import adc1_axil_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [ADC_W-1:0] adc_data_i,
   input  logic             adc_valid_i,
   input  logic             enable_i,
   input  logic             clear_i,
   output logic [ADC_W-1:0] sample_o,
   output logic             valid_o,
   output logic             overrun_o
);

   logic [ADC_W-1:0] sample_q, sample_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;

   // A fresh sample wins over a simultaneous clear; overrun then reflects the prior valid.
   always_comb begin
      sample_d  = sample_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (adc_valid_i && enable_i) begin
         sample_d  = adc_data_i;
         valid_d   = 1'b1;
         overrun_d = overrun_q | valid_q;
      end else if (clear_i) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end else begin
         valid_d   = valid_q;
         overrun_d = overrun_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sample_q  <= {ADC_W{1'b0}};
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign sample_o  = sample_q;
   assign valid_o   = valid_q;
   assign overrun_o = overrun_q;

endmodule

// File: rtl/adc1_axil_slave.sv
// AXI4-Lite slave exposing CTRL, CLKDIV, SAMPLE and SCRATCH registers for an ADC,
// with independent write and read channel FSMs.
module adc1_axil_slave
   import adc1_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
)(
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   input  logic [ADC_W-1:0]                adc_data,
   input  logic                            adc_valid,
   output logic                            adc_enable,
   output logic [CLKDIV_W-1:0]             adc_clkdiv,
   output logic                            irq
);

   logic [1:0]          ctrl_q, ctrl_d;
   logic [CLKDIV_W-1:0] clkdiv_q, clkdiv_d;
   logic [31:0]         scratch_q, scratch_d;
   wstate_e             wstate_q, wstate_d;
   logic                aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [1:0]          awsel_q, awsel_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          wstrb_q, wstrb_d;
   logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   rstate_e             rstate_q, rstate_d;
   logic                arready_q, arready_d, rvalid_q, rvalid_d;
   logic [31:0]         rdata_q, rdata_d;

   logic [ADC_W-1:0]    sample;
   logic                sample_valid, sample_ovr;
   logic [31:0]         sample_word, wr_cur, wr_merged;
   logic                aw_hs, w_hs, ar_hs, aw_have, w_have;
   logic [1:0]          wr_sel;
   logic [31:0]         wr_data;
   logic [3:0]          wr_strb;
   logic                unused_bits;

   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign aw_hs   = S_AXI_AWVALID & awready_q;
   assign w_hs    = S_AXI_WVALID & wready_q;
   assign ar_hs   = S_AXI_ARVALID & arready_q;
   assign aw_have = aw_held_q | aw_hs;
   assign w_have  = w_held_q | w_hs;
   assign wr_sel  = aw_held_q ? awsel_q : S_AXI_AWADDR[3:2];
   assign wr_data = w_held_q ? wdata_q : S_AXI_WDATA;
   assign wr_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;

   assign sample_word = {sample_valid, sample_ovr, {(30-ADC_W){1'b0}}, sample};
   assign wr_cur      = reg_word(wr_sel, ctrl_q, clkdiv_q, sample_word, scratch_q);
   assign wr_merged   = apply_wstrb(wr_cur, wr_data, wr_strb);

   adc1_sample_capture u_capture (
      .clk_i       (S_AXI_ACLK),
      .rst_ni      (S_AXI_ARESETN),
      .adc_data_i  (adc_data),
      .adc_valid_i (adc_valid),
      .enable_i    (ctrl_q[CTRL_EN_BIT]),
      .clear_i     (ar_hs && (S_AXI_ARADDR[3:2] == REG_SAMPLE)),
      .sample_o    (sample),
      .valid_o     (sample_valid),
      .overrun_o   (sample_ovr)
   );

   // AW and W are latched independently; the register update fires once both are present.
   always_comb begin
      ctrl_d    = ctrl_q;
      clkdiv_d  = clkdiv_q;
      scratch_d = scratch_q;
      wstate_d  = wstate_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awsel_d   = awsel_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      case (wstate_q)
         W_IDLE: begin
            if (aw_have && w_have) begin
               wstate_d  = W_RESP;
               bvalid_d  = 1'b1;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               case (wr_sel)
                  REG_CTRL:    ctrl_d    = wr_merged[1:0];
                  REG_CLKDIV:  clkdiv_d  = wr_merged[CLKDIV_W-1:0];
                  REG_SCRATCH: scratch_d = wr_merged;
                  default:     scratch_d = scratch_q;
               endcase
            end else begin
               if (aw_hs) begin
                  aw_held_d = 1'b1;
                  awsel_d   = S_AXI_AWADDR[3:2];
               end else begin
                  aw_held_d = aw_held_q;
               end
               if (w_hs) begin
                  w_held_d = 1'b1;
                  wdata_d  = S_AXI_WDATA;
                  wstrb_d  = S_AXI_WSTRB;
               end else begin
                  w_held_d = w_held_q;
               end
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) begin
               wstate_d = W_IDLE;
               bvalid_d = 1'b0;
            end else begin
               bvalid_d = 1'b1;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
      awready_d = (wstate_d == W_IDLE) && !aw_held_d;
      wready_d  = (wstate_d == W_IDLE) && !w_held_d;
   end

   always_comb begin
      rstate_d = rstate_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      case (rstate_q)
         R_IDLE: begin
            if (ar_hs) begin
               rstate_d = R_DATA;
               rvalid_d = 1'b1;
               rdata_d  = reg_word(S_AXI_ARADDR[3:2], ctrl_q, clkdiv_q, sample_word, scratch_q);
            end else begin
               rvalid_d = 1'b0;
            end
         end
         R_DATA: begin
            if (S_AXI_RREADY) begin
               rstate_d = R_IDLE;
               rvalid_d = 1'b0;
            end else begin
               rvalid_d = 1'b1;
            end
         end
         default: rstate_d = R_IDLE;
      endcase
      arready_d = (rstate_d == R_IDLE);
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         ctrl_q    <= 2'd0;
         clkdiv_q  <= {CLKDIV_W{1'b0}};
         scratch_q <= 32'd0;
         wstate_q  <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awsel_q   <= 2'd0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= 32'd0;
      end else begin
         ctrl_q    <= ctrl_d;
         clkdiv_q  <= clkdiv_d;
         scratch_q <= scratch_d;
         wstate_q  <= wstate_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         awsel_q   <= awsel_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         rstate_q  <= rstate_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = RESP_OKAY;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = RESP_OKAY;
   assign adc_enable    = ctrl_q[CTRL_EN_BIT];
   assign adc_clkdiv    = clkdiv_q;
   assign irq           = ctrl_q[CTRL_IRQEN_BIT] & sample_valid;

endmodule

// File: tb/tb_adc1_axil_slave.sv
// Directed self-checking bench for adc1_axil_slave: register map, split AW/W,
// sample capture/overrun/irq, backpressure, concurrent access and mid-transaction reset.
module tb_adc1_axil_slave;

   logic        clk;
   logic        rstn;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic [11:0] adc_data;
   logic        adc_valid, adc_enable, irq;
   logic [15:0] adc_clkdiv;

   int total = 0;
   int bad   = 0;
   int bcount = 0;

   adc1_axil_slave dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rstn),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .adc_data      (adc_data),
      .adc_valid     (adc_valid),
      .adc_enable    (adc_enable),
      .adc_clkdiv    (adc_clkdiv),
      .irq           (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bvalid && bready) bcount <= bcount + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      bit aw_done, w_done, awf, wf;
      int n;
      aw_done = 0; w_done = 0; n = 0;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      while (!(aw_done && w_done) && n < 20) begin
         awf = awvalid && awready;
         wf  = wvalid && wready;
         tick(); n++;
         if (awf) begin aw_done = 1; awvalid = 1'b0; end
         if (wf)  begin w_done = 1;  wvalid  = 1'b0; end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 20) begin tick(); n++; end
      total++;
      if (bvalid !== 1'b1) begin bad++; $display("FAIL write_bvalid addr=%h got=%b want=1", a, bvalid); end
      bready = 1'b1; tick(); bready = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
      int n;
      araddr = a; arvalid = 1'b1; n = 0;
      while (!arready && n < 20) begin tick(); n++; end
      tick(); arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin tick(); n++; end
      total++;
      if (rvalid !== 1'b1) begin bad++; $display("FAIL read_rvalid addr=%h got=%b want=1", a, rvalid); end
      d = rdata;
      rready = 1'b1; tick(); rready = 1'b0;
   endtask

   task automatic adc_pulse(input logic [11:0] d);
      adc_data = d; adc_valid = 1'b1; tick(); adc_valid = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; tick(); tick();
      total++;
      if ({awready, wready, arready, bvalid, rvalid, irq, adc_enable} !== 7'd0) begin
         bad++; $display("FAIL reset_flags got=%b want=0000000", {awready, wready, arready, bvalid, rvalid, irq, adc_enable});
      end
      total++;
      if ({rdata, adc_clkdiv, bresp, rresp} !== 52'd0) begin
         bad++; $display("FAIL reset_data rdata=%h clkdiv=%h bresp=%b rresp=%b want all 0", rdata, adc_clkdiv, bresp, rresp);
      end
      rstn = 1'b1; tick();
      total++;
      if ({awready, wready, arready} !== 3'b111) begin
         bad++; $display("FAIL ready_after_reset got=%b want=111", {awready, wready, arready});
      end
   endtask

   task automatic test_regmap();
      logic [31:0] rd;
      logic [31:0] exp_v [4];
      exp_v[0] = 32'h1; exp_v[1] = 32'h2; exp_v[2] = 32'h0; exp_v[3] = 32'h4;
      for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF);
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(i * 4), rd);
         total++;
         if (rd !== exp_v[i]) begin bad++; $display("FAIL regmap_%0d got=%h want=%h", i, rd, exp_v[i]); end
      end
      total++;
      if ({adc_enable, adc_clkdiv} !== {1'b1, 16'h0002}) begin
         bad++; $display("FAIL regmap_outputs got en=%b div=%h want en=1 div=0002", adc_enable, adc_clkdiv);
      end
   endtask

   task automatic test_w_before_aw();
      logic [31:0] rd;
      int b0;
      axi_write(4'hC, 32'h11223344, 4'hF);
      b0 = bcount;
      wdata = 32'hDEADBEEF; wstrb = 4'b0011; wvalid = 1'b1;
      tick(); wvalid = 1'b0;
      total++;
      if (wready !== 1'b0) begin bad++; $display("FAIL w_held_wready got=%b want=0", wready); end
      tick(); tick();
      total++;
      if (bvalid !== 1'b0) begin bad++; $display("FAIL w_only_bvalid got=%b want=0", bvalid); end
      awaddr = 4'hC; awvalid = 1'b1; tick(); awvalid = 1'b0;
      total++;
      if (bvalid !== 1'b1) begin bad++; $display("FAIL split_bvalid got=%b want=1", bvalid); end
      bready = 1'b1; tick(); bready = 1'b0;
      tick(); tick(); tick();
      total++;
      if (bcount - b0 !== 1) begin bad++; $display("FAIL split_bcount got=%0d want=1", bcount - b0); end
      axi_read(4'hC, rd);
      total++;
      if (rd !== 32'h1122BEEF) begin bad++; $display("FAIL split_strb got=%h want=1122beef", rd); end
      axi_write(4'hC, 32'h00000000, 4'h0);
      axi_read(4'hC, rd);
      total++;
      if (rd !== 32'h1122BEEF) begin bad++; $display("FAIL strb_zero got=%h want=1122beef", rd); end
      axi_write(4'h8, 32'hFFFFFFFF, 4'hF);
      axi_read(4'h8, rd);
      total++;
      if (rd !== 32'h00000000) begin bad++; $display("FAIL sample_ro got=%h want=00000000", rd); end
   endtask

   task automatic test_sample();
      logic [31:0] rd;
      axi_write(4'h0, 32'h1, 4'hF);
      adc_pulse(12'hABC);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b want=0", irq); end
      axi_read(4'h8, rd);
      total++;
      if (rd !== 32'h80000ABC) begin bad++; $display("FAIL sample_first got=%h want=80000abc", rd); end
      axi_read(4'h8, rd);
      total++;
      if (rd !== 32'h00000ABC) begin bad++; $display("FAIL sample_second got=%h want=00000abc", rd); end
   endtask

   task automatic test_overrun();
      logic [31:0] rd;
      axi_write(4'h0, 32'h3, 4'hF);
      adc_pulse(12'h111);
      adc_pulse(12'h222);
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b want=1", irq); end
      axi_read(4'h8, rd);
      total++;
      if (rd !== 32'hC0000222) begin bad++; $display("FAIL overrun got=%h want=c0000222", rd); end
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL irq_cleared got=%b want=0", irq); end
      axi_write(4'h0, 32'h2, 4'hF);
      adc_pulse(12'h333);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL disabled_irq got=%b want=0", irq); end
      axi_read(4'h8, rd);
      total++;
      if (rd !== 32'h00000222) begin bad++; $display("FAIL disabled_ignored got=%h want=00000222", rd); end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd;
      awaddr = 4'h4; wdata = 32'h00005A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awaddr = 4'hC; wdata = 32'h0;
      for (int i = 0; i < 10; i++) begin
         total++;
         if ({bvalid, awready, wready} !== 3'b100) begin
            bad++; $display("FAIL bp_write_%0d bvalid/awready/wready got=%b want=100", i, {bvalid, awready, wready});
         end
         tick();
      end
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1; tick(); bready = 1'b0;
      total++;
      if (adc_clkdiv !== 16'h5A5A) begin bad++; $display("FAIL bp_clkdiv got=%h want=5a5a", adc_clkdiv); end
      araddr = 4'h4; arvalid = 1'b1; tick();
      for (int i = 0; i < 10; i++) begin
         total++;
         if ({rvalid, arready, rdata} !== {2'b10, 32'h00005A5A}) begin
            bad++; $display("FAIL bp_read_%0d rvalid=%b arready=%b rdata=%h want 1 0 00005a5a", i, rvalid, arready, rdata);
         end
         tick();
      end
      arvalid = 1'b0; rready = 1'b1; tick(); rready = 1'b0;
      total++;
      if (rvalid !== 1'b0) begin bad++; $display("FAIL bp_rvalid_drop got=%b want=0", rvalid); end
      axi_read(4'hC, rd);
      total++;
      if (rd !== 32'h1122BEEF) begin bad++; $display("FAIL bp_no_new_write got=%h want=1122beef", rd); end
   endtask

   task automatic test_concurrent();
      logic [31:0] rd;
      awaddr = 4'hC; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 4'hC;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      total++;
      if ({bvalid, rvalid, rdata} !== {2'b11, 32'h1122BEEF}) begin
         bad++; $display("FAIL concurrent_old bvalid=%b rvalid=%b rdata=%h want 1 1 1122beef", bvalid, rvalid, rdata);
      end
      bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
      axi_read(4'hC, rd);
      total++;
      if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL concurrent_new got=%h want=cafef00d", rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      axi_write(4'h0, 32'h3, 4'hF);
      awaddr = 4'h0; awvalid = 1'b1; tick(); awvalid = 1'b0;
      total++;
      if (awready !== 1'b0) begin bad++; $display("FAIL mid_aw_latched got=%b want=0", awready); end
      rstn = 1'b0; tick(); tick();
      rstn = 1'b1; tick();
      total++;
      if ({bvalid, adc_enable, irq} !== 3'b000) begin
         bad++; $display("FAIL mid_after_reset bvalid/en/irq got=%b want=000", {bvalid, adc_enable, irq});
      end
      wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1; tick(); wvalid = 1'b0;
      tick(); tick();
      total++;
      if (bvalid !== 1'b0) begin bad++; $display("FAIL mid_aw_discarded got=%b want=0", bvalid); end
      awaddr = 4'h0; awvalid = 1'b1; tick(); awvalid = 1'b0;
      total++;
      if (bvalid !== 1'b1) begin bad++; $display("FAIL mid_next_write got=%b want=1", bvalid); end
      bready = 1'b1; tick(); bready = 1'b0;
      axi_read(4'h0, rd);
      total++;
      if (rd !== 32'h00000001) begin bad++; $display("FAIL mid_ctrl got=%h want=00000001", rd); end
   endtask

   initial begin
      rstn = 1'b0;
      awaddr = 4'h0; araddr = 4'h0; awprot = 3'd0; arprot = 3'd0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      wdata = 32'h0; wstrb = 4'h0; adc_data = 12'h0; adc_valid = 1'b0;
      test_reset();
      test_regmap();
      test_w_before_aw();
      test_sample();
      test_overrun();
      test_backpressure();
      test_concurrent();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
